mem_lsu: RTL and testbench
==========================

MEM_LSU -- requirements
Module: mem_lsu

Interface
REQ-001 Parameter TIMEOUT, default 255, is the maximum number of cycles to wait for bus_ack before aborting (range 1..255).
REQ-002 cpu_clk  in  1  single clock; all state changes on its rising edge.
REQ-003 cpu_rst_n  in  1  asynchronous, active-low reset.
REQ-004 ld_MEM_in  in  1  load request from EX/MEM register.
REQ-005 ram_we_MEM_in  in  1  store request from EX/MEM register; ld and we both high is illegal, and store wins.
REQ-006 size_MEM_in  in  3  funct3: 000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu; stores use only 000/001/010.
REQ-007 ALU_C_MEM_in  in  32  byte address.
REQ-008 rD2_MEM_in  in  32  store data.
REQ-009 lsu_stall  out  1  freezes PC, IF/ID, ID/EX and EX/MEM while high.
REQ-010 rdata_MEM_out  out  32  aligned, extended load result; valid in DONE.
REQ-011 misalign_err  out  1  one-cycle pulse, misaligned access.
REQ-012 bus_err  out  1  one-cycle pulse, ack timeout.
REQ-013 bus_req / bus_we  out  1 / 1  request and direction, registered.
REQ-014 bus_addr  out  32  word address {ALU_C[31:2],2'b00}, registered.
REQ-015 bus_be / bus_wdata  out  4 / 32  byte enables and store data, registered.
REQ-016 bus_ack / bus_rdata  in  1 / 32  completion strobe and read word.

Function
REQ-017 The FSM SHALL have states IDLE, REQ and DONE.
REQ-018 IDLE: an aligned op (ld or we high) SHALL go to REQ, latch bus_* and clear the timeout counter.
REQ-019 lsu_stall SHALL be combinational: high in IDLE with an aligned op pending, high throughout REQ, and low in DONE.
REQ-020 REQ: bus_req SHALL stay high with stable address, be, we and wdata until the cycle bus_ack is sampled high.
REQ-021 On ack the FSM SHALL go to DONE, capture bus_rdata and drop bus_req in the same edge.
REQ-022 The counter SHALL increment each REQ cycle without ack; on reaching TIMEOUT the FSM SHALL go to DONE, pulse bus_err, force captured data to 0 and drop bus_req.
REQ-023 DONE SHALL go to IDLE unconditionally and SHALL last one cycle, so the held EX/MEM op is not reissued.
REQ-024 Minimum latency SHALL be 3 cycles from op visible in IDLE to pipeline release (IDLE, REQ with ack, DONE).
REQ-025 Byte enables: byte = 4'b0001<<A[1:0]; half = 4'b0011<<{A[1],1'b0}; word = 4'b1111. The same enables SHALL apply to loads.
REQ-026 Store wdata SHALL replicate the byte 4x for sb, replicate the half 2x for sh, and pass the word unchanged for sw.
REQ-027 Load result: select the byte or half by A[1:0] from the captured word; sign-extend lb/lh and zero-extend lbu/lhu.
REQ-028 Misaligned accesses are half with A[0]=1 and word with A[1:0]!=0. They SHALL issue no bus request, raise no stall, pulse misalign_err once, and drive rdata_MEM_out to 0.
REQ-029 A bus_ack seen outside REQ SHALL be ignored.
REQ-030 Outside DONE, rdata_MEM_out SHALL hold its last value.

Reset
REQ-031 Asserting cpu_rst_n low SHALL immediately force IDLE, bus_req=0, bus_we=0, bus_be=0, bus_addr=0, bus_wdata=0, the counter and captured data to 0, and both error pulses to 0, including mid-REQ.
REQ-032 After release, the first op SHALL be accepted on the first rising edge with cpu_rst_n high.

Structure
REQ-033 Package mem_pkg SHALL hold the funct3 size encodings, the FSM state enum and the TIMEOUT default.
REQ-034 Byte-lane select and extension SHALL live in a combinational sub-module load_align.

Verification
REQ-035 lw at 0x100, ack on the first REQ cycle with rdata 0xDEADBEEF -> stall for 2 cycles, rdata_MEM_out=0xDEADBEEF in DONE, bus_be=1111.
REQ-036 lb at 0x103 with word 0x80112233 -> be=1000, result 0xFFFFFF80; lbu at the same address -> 0x00000080.
REQ-037 sh at 0x202 with rD2=0x0000ABCD -> bus_we=1, be=1100, wdata=0xABCDABCD, addr=0x200.
REQ-038 lw at 0x101 -> misalign_err for exactly 1 cycle, bus_req never high, lsu_stall low.
REQ-039 TIMEOUT=4 with ack withheld -> bus_req high 4 cycles, bus_err pulse, result 0, return to IDLE.
REQ-040 cpu_rst_n low during the 2nd REQ cycle -> bus_req low in the same cycle with no edge, IDLE after release, late ack ignored.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared definitions for the memory load/store unit:
// funct3 size codes, FSM states and lane helpers.
package mem_pkg;

    localparam int TIMEOUT_DEF = 255;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_DONE
    } state_t;

    function automatic logic is_misaligned(
        input logic [2:0] sz,
        input logic [1:0] a
    );
        logic r;
        r = 1'b0;
        case (sz[1:0])
            2'b01:   r = a[0];
            2'b10:   r = (a != 2'b00);
            default: r = 1'b0;
        endcase
        return r;
    endfunction

    function automatic logic [3:0] be_of(
        input logic [2:0] sz,
        input logic [1:0] a
    );
        logic [3:0] r;
        r = 4'b1111;
        case (sz[1:0])
            2'b00:   r = 4'b0001 << a;
            2'b01:   r = 4'b0011 << {a[1], 1'b0};
            default: r = 4'b1111;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] wdata_of(
        input logic [2:0]  sz,
        input logic [31:0] d
    );
        logic [31:0] r;
        r = d;
        case (sz[1:0])
            2'b00:   r = {4{d[7:0]}};
            2'b01:   r = {2{d[15:0]}};
            default: r = d;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/mem_lsu_if.sv
// Data-memory bus between the LSU (master)
// and the memory or interconnect (slave).
interface mem_lsu_if;

    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic        bus_ack;
    logic [31:0] bus_rdata;

    modport master (
        output bus_req,
        output bus_we,
        output bus_addr,
        output bus_be,
        output bus_wdata,
        input  bus_ack,
        input  bus_rdata
    );

    modport slave (
        input  bus_req,
        input  bus_we,
        input  bus_addr,
        input  bus_be,
        input  bus_wdata,
        output bus_ack,
        output bus_rdata
    );

endinterface

// File: rtl/mem_lsu_load_align.sv
// Picks the addressed byte/half out of a read word
// and sign- or zero-extends it to 32 bits.
module load_align (
    input  logic [31:0] word_i,
    input  logic [2:0]  size_i,
    input  logic [1:0]  off_i,
    output logic [31:0] data_o
);

    logic [31:0] shifted;
    logic [7:0]  b;
    logic [15:0] h;
    logic        sx;

    // lane select then extension, bit 2 of funct3 means unsigned
    always_comb begin
        shifted = word_i >> {off_i, 3'b000};
        b       = shifted[7:0];
        h       = off_i[1] ? word_i[31:16] : word_i[15:0];
        sx      = ~size_i[2];
        data_o  = word_i;
        case (size_i[1:0])
            2'b00:   data_o = {{24{sx & b[7]}}, b};
            2'b01:   data_o = {{16{sx & h[15]}}, h};
            default: data_o = word_i;
        endcase
    end

endmodule

// File: rtl/mem_lsu.sv
// MEM-stage load/store unit: one bus transaction per
// EX/MEM op, stalling the pipeline until it completes.
module mem_lsu
    import mem_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic        cpu_clk,
    input  logic        cpu_rst_n,
    input  logic        ld_MEM_in,
    input  logic        ram_we_MEM_in,
    input  logic [2:0]  size_MEM_in,
    input  logic [31:0] ALU_C_MEM_in,
    input  logic [31:0] rD2_MEM_in,
    output logic        lsu_stall,
    output logic [31:0] rdata_MEM_out,
    output logic        misalign_err,
    output logic        bus_err,
    mem_lsu_if.master   bus
);

    localparam logic [7:0] TO = 8'(TIMEOUT);

    state_t      state_q, state_d;
    logic        req_q, req_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [3:0]  be_q, be_d;
    logic [31:0] wdata_q, wdata_d;
    logic [2:0]  size_q, size_d;
    logic [1:0]  off_q, off_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [31:0] rdata_q, rdata_d;
    logic        mis_q, mis_d;
    logic        berr_q, berr_d;

    logic        op;
    logic        mis;
    logic [31:0] aligned;

    load_align u_align (
        .word_i (bus.bus_rdata),
        .size_i (size_q),
        .off_i  (off_q),
        .data_o (aligned)
    );

    assign op  = ld_MEM_in | ram_we_MEM_in;
    assign mis = is_misaligned(size_MEM_in, ALU_C_MEM_in[1:0]);

    // next-state, bus latching and stall decode
    always_comb begin
        state_d   = state_q;
        req_d     = req_q;
        we_d      = we_q;
        addr_d    = addr_q;
        be_d      = be_q;
        wdata_d   = wdata_q;
        size_d    = size_q;
        off_d     = off_q;
        cnt_d     = cnt_q;
        rdata_d   = rdata_q;
        mis_d     = 1'b0;
        berr_d    = 1'b0;
        lsu_stall = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (op && mis) begin
                    mis_d   = 1'b1;
                    rdata_d = '0;
                end else if (op) begin
                    lsu_stall = 1'b1;
                    state_d   = S_REQ;
                    req_d     = 1'b1;
                    we_d      = ram_we_MEM_in;
                    addr_d    = {ALU_C_MEM_in[31:2], 2'b00};
                    be_d      = be_of(size_MEM_in, ALU_C_MEM_in[1:0]);
                    wdata_d   = wdata_of(size_MEM_in, rD2_MEM_in);
                    size_d    = size_MEM_in;
                    off_d     = ALU_C_MEM_in[1:0];
                    cnt_d     = '0;
                end
            end
            S_REQ: begin
                lsu_stall = 1'b1;
                if (bus.bus_ack) begin
                    state_d = S_DONE;
                    req_d   = 1'b0;
                    rdata_d = aligned;
                end else if (cnt_q + 8'd1 >= TO) begin
                    state_d = S_DONE;
                    req_d   = 1'b0;
                    berr_d  = 1'b1;
                    rdata_d = '0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // state and registered bus outputs
    always_ff @(posedge cpu_clk or negedge cpu_rst_n) begin
        if (!cpu_rst_n) begin
            state_q <= S_IDLE;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            be_q    <= '0;
            wdata_q <= '0;
            size_q  <= '0;
            off_q   <= '0;
            cnt_q   <= '0;
            rdata_q <= '0;
            mis_q   <= 1'b0;
            berr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            be_q    <= be_d;
            wdata_q <= wdata_d;
            size_q  <= size_d;
            off_q   <= off_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            mis_q   <= mis_d;
            berr_q  <= berr_d;
        end
    end

    assign bus.bus_req   = req_q;
    assign bus.bus_we    = we_q;
    assign bus.bus_addr  = addr_q;
    assign bus.bus_be    = be_q;
    assign bus.bus_wdata = wdata_q;
    assign rdata_MEM_out = rdata_q;
    assign misalign_err  = mis_q;
    assign bus_err       = berr_q;

endmodule

// File: tb/tb_mem_lsu.sv
// Randomized self-checking bench for mem_lsu against
// an arithmetic reference model of the access rules.
module tb_mem_lsu;
    import mem_pkg::*;

    logic        cpu_clk = 1'b0;
    logic        cpu_rst_n = 1'b0;
    logic        ld_in = 1'b0;
    logic        we_in = 1'b0;
    logic [2:0]  size_in = '0;
    logic [31:0] addr_in = '0;
    logic [31:0] wd_in = '0;
    logic        lsu_stall;
    logic [31:0] rdata_out;
    logic        misalign_err;
    logic        bus_err;

    mem_lsu_if bif ();

    mem_lsu #(.TIMEOUT(4)) dut (
        .cpu_clk       (cpu_clk),
        .cpu_rst_n     (cpu_rst_n),
        .ld_MEM_in     (ld_in),
        .ram_we_MEM_in (we_in),
        .size_MEM_in   (size_in),
        .ALU_C_MEM_in  (addr_in),
        .rD2_MEM_in    (wd_in),
        .lsu_stall     (lsu_stall),
        .rdata_MEM_out (rdata_out),
        .misalign_err  (misalign_err),
        .bus_err       (bus_err),
        .bus           (bif)
    );

    always #5 cpu_clk = ~cpu_clk;

    int n_pass = 0;
    int n_chk = 0;

    int          o_stall_cyc, o_req_cyc, o_unstable;
    logic        o_done, o_berr, o_we;
    logic [3:0]  o_be;
    logic [31:0] o_addr, o_wdata, o_rdata;

    function automatic logic [3:0] m_be(logic [2:0] sz, logic [31:0] a);
        int k = int'(a % 4);
        if (sz[1:0] == 2'b00) return 4'(1 << k);
        if (sz[1:0] == 2'b01) return 4'(3 << (k & 2));
        return 4'hf;
    endfunction

    function automatic logic [31:0] m_wdata(logic [2:0] sz, logic [31:0] d);
        if (sz[1:0] == 2'b00) return {24'd0, d[7:0]} * 32'h01010101;
        if (sz[1:0] == 2'b01) return {16'd0, d[15:0]} * 32'h00010001;
        return d;
    endfunction

    function automatic logic [31:0] m_load(logic [2:0] sz, logic [31:0] a,
                                           logic [31:0] w);
        int k = int'(a % 4);
        logic [31:0] v;
        if (sz[1:0] == 2'b00) begin
            v = (w >> (8 * k)) & 32'hff;
            if (sz[2] == 1'b0 && v >= 128) v = v | 32'hffffff00;
        end else if (sz[1:0] == 2'b01) begin
            v = (w >> (8 * (k & 2))) & 32'hffff;
            if (sz[2] == 1'b0 && v >= 32768) v = v | 32'hffff0000;
        end else begin
            v = w;
        end
        return v;
    endfunction

    function automatic logic m_mis(logic [2:0] sz, logic [31:0] a);
        return (sz[1:0] == 2'b01 && a % 2 != 0) ||
               (sz[1:0] == 2'b10 && a % 4 != 0);
    endfunction

    // drives one op (called just after a rising edge) and acts as slave
    task automatic run_op(input logic l, input logic w, input logic [2:0] sz,
                          input logic [31:0] a, input logic [31:0] d,
                          input int dly, input logic [31:0] word);
        ld_in = l; we_in = w; size_in = sz; addr_in = a; wd_in = d;
        bif.bus_rdata = word;
        bif.bus_ack = 1'b0;
        o_done = 0; o_req_cyc = 0; o_stall_cyc = 0; o_unstable = 0;
        o_berr = 0; o_rdata = '0;
        #1;
        for (int c = 0; c < 40 && !o_done; c++) begin
            if (lsu_stall) o_stall_cyc++;
            bif.bus_ack = 1'b0;
            if (bif.bus_req) begin
                if (o_req_cyc == 0) begin
                    o_be = bif.bus_be; o_addr = bif.bus_addr;
                    o_we = bif.bus_we; o_wdata = bif.bus_wdata;
                end else if ({bif.bus_be, bif.bus_addr, bif.bus_we, bif.bus_wdata}
                             !== {o_be, o_addr, o_we, o_wdata}) begin
                    o_unstable++;
                end
                bif.bus_ack = (o_req_cyc == dly);
                o_req_cyc++;
            end
            if (c > 0 && !lsu_stall) begin
                o_done = 1; o_rdata = rdata_out; o_berr = bus_err;
                ld_in = 0; we_in = 0;
            end
            @(posedge cpu_clk); #1;
        end
        bif.bus_ack = 1'b0;
    endtask

    task automatic test_reset();
        bif.bus_ack = 0; bif.bus_rdata = '0;
        cpu_rst_n = 0;
        repeat (3) @(posedge cpu_clk);
        #1;
        if ({bif.bus_req, bif.bus_we, bif.bus_be} !== 6'd0) begin
            $display("FAIL reset_ctrl got=%b exp=0", {bif.bus_req, bif.bus_we, bif.bus_be});
        end else n_pass++;
        n_chk++;
        if ({bif.bus_addr, bif.bus_wdata, rdata_out} !== 96'd0) begin
            $display("FAIL reset_data addr=%h wdata=%h rdata=%h exp=0",
                     bif.bus_addr, bif.bus_wdata, rdata_out);
        end else n_pass++;
        n_chk++;
        if ({lsu_stall, misalign_err, bus_err} !== 3'd0) begin
            $display("FAIL reset_flags got=%b exp=000", {lsu_stall, misalign_err, bus_err});
        end else n_pass++;
        n_chk++;
        cpu_rst_n = 1;
    endtask

    task automatic test_lw();
        run_op(1, 0, F3_W, 32'h100, 32'h0, 0, 32'hDEADBEEF);
        if ({o_done, o_stall_cyc[3:0], o_req_cyc[3:0]} !== {1'b1, 4'd2, 4'd1}) begin
            $display("FAIL lw_timing done=%0d stall=%0d req=%0d exp 1/2/1",
                     o_done, o_stall_cyc, o_req_cyc);
        end else n_pass++;
        n_chk++;
        if (o_rdata !== 32'hDEADBEEF) begin
            $display("FAIL lw_rdata got=%h exp=deadbeef", o_rdata);
        end else n_pass++;
        n_chk++;
        if ({o_be, o_addr, o_we} !== {4'hf, 32'h100, 1'b0}) begin
            $display("FAIL lw_bus be=%b addr=%h we=%b exp 1111/100/0", o_be, o_addr, o_we);
        end else n_pass++;
        n_chk++;
    endtask

    task automatic test_lb_lbu();
        run_op(1, 0, F3_B, 32'h103, 32'h0, 1, 32'h80112233);
        if (o_be !== 4'b1000) begin
            $display("FAIL lb_be got=%b exp=1000", o_be);
        end else n_pass++;
        n_chk++;
        if (o_rdata !== 32'hFFFFFF80) begin
            $display("FAIL lb_rdata got=%h exp=ffffff80", o_rdata);
        end else n_pass++;
        n_chk++;
        run_op(1, 0, F3_BU, 32'h103, 32'h0, 0, 32'h80112233);
        if (o_rdata !== 32'h00000080) begin
            $display("FAIL lbu_rdata got=%h exp=00000080", o_rdata);
        end else n_pass++;
        n_chk++;
    endtask

    task automatic test_sh();
        run_op(0, 1, F3_H, 32'h202, 32'h0000ABCD, 0, 32'h0);
        if ({o_we, o_be, o_addr} !== {1'b1, 4'b1100, 32'h200}) begin
            $display("FAIL sh_bus we=%b be=%b addr=%h exp 1/1100/200", o_we, o_be, o_addr);
        end else n_pass++;
        n_chk++;
        if (o_wdata !== 32'hABCDABCD) begin
            $display("FAIL sh_wdata got=%h exp=abcdabcd", o_wdata);
        end else n_pass++;
        n_chk++;
    endtask

    task automatic test_misalign();
        logic [2:0]  sz;
        logic [31:0] a;
        int          req_seen;
        for (int i = 0; i < 8; i++) begin
            sz = (i % 2 == 0) ? F3_W : ((i % 4 == 1) ? F3_H : F3_HU);
            a = $urandom;
            if (i == 0) a = 32'h101;
            if (!m_mis(sz, a)) a[0] = 1'b1;
            ld_in = (i != 3); we_in = (i == 3); size_in = sz;
            addr_in = a; wd_in = $urandom;
            #1;
            req_seen = bif.bus_req ? 1 : 0;
            if (lsu_stall !== 1'b0) begin
                $display("FAIL mis_stall i=%0d got=%b exp=0", i, lsu_stall);
            end else n_pass++;
            n_chk++;
            @(posedge cpu_clk); #1;
            if (bif.bus_req) req_seen++;
            if (misalign_err !== 1'b1) begin
                $display("FAIL mis_pulse i=%0d got=%b exp=1", i, misalign_err);
            end else n_pass++;
            n_chk++;
            ld_in = 0; we_in = 0;
            @(posedge cpu_clk); #1;
            if (bif.bus_req) req_seen++;
            if ({misalign_err, rdata_out} !== 33'd0 || req_seen != 0) begin
                $display("FAIL mis_after i=%0d err=%b rdata=%h req=%0d exp 0/0/0",
                         i, misalign_err, rdata_out, req_seen);
            end else n_pass++;
            n_chk++;
        end
    endtask

    task automatic test_timeout();
        run_op(1, 0, F3_W, 32'h440, 32'h0, 99, 32'h12345678);
        if ({o_done, o_req_cyc[3:0], o_stall_cyc[3:0]} !== {1'b1, 4'd4, 4'd5}) begin
            $display("FAIL to_timing done=%0d req=%0d stall=%0d exp 1/4/5",
                     o_done, o_req_cyc, o_stall_cyc);
        end else n_pass++;
        n_chk++;
        if ({o_berr, o_rdata} !== {1'b1, 32'h0}) begin
            $display("FAIL to_result berr=%b rdata=%h exp 1/0", o_berr, o_rdata);
        end else n_pass++;
        n_chk++;
        if ({bus_err, lsu_stall, bif.bus_req} !== 3'b000) begin
            $display("FAIL to_idle got=%b exp=000", {bus_err, lsu_stall, bif.bus_req});
        end else n_pass++;
        n_chk++;
    endtask

    task automatic test_rst_mid_req();
        ld_in = 1; we_in = 0; size_in = F3_W; addr_in = 32'h300;
        bif.bus_ack = 0;
        @(posedge cpu_clk); #1;
        if (bif.bus_req !== 1'b1) begin
            $display("FAIL rst_req1 got=%b exp=1", bif.bus_req);
        end else n_pass++;
        n_chk++;
        @(posedge cpu_clk); #2;
        cpu_rst_n = 0;
        ld_in = 0;
        #1;
        if ({bif.bus_req, bif.bus_be, bif.bus_addr, lsu_stall} !== 38'd0) begin
            $display("FAIL rst_async req=%b be=%b addr=%h stall=%b exp 0",
                     bif.bus_req, bif.bus_be, bif.bus_addr, lsu_stall);
        end else n_pass++;
        n_chk++;
        @(posedge cpu_clk); #1;
        cpu_rst_n = 1;
        bif.bus_ack = 1;
        @(posedge cpu_clk); #1;
        bif.bus_ack = 0;
        if ({bif.bus_req, lsu_stall, bus_err, rdata_out} !== 35'd0) begin
            $display("FAIL rst_late_ack req=%b stall=%b err=%b rdata=%h exp 0",
                     bif.bus_req, lsu_stall, bus_err, rdata_out);
        end else n_pass++;
        n_chk++;
        run_op(1, 0, F3_H, 32'h306, 32'h0, 1, 32'h8001CAFE);
        if ({o_req_cyc[3:0], o_rdata} !== {4'd2, 32'hFFFF8001}) begin
            $display("FAIL rst_next_op req=%0d rdata=%h exp 2/ffff8001", o_req_cyc, o_rdata);
        end else n_pass++;
        n_chk++;
    endtask

    task automatic test_random();
        logic [2:0]  sizes [5] = '{F3_B, F3_H, F3_W, F3_BU, F3_HU};
        logic [2:0]  sz;
        logic [31:0] a, d, w;
        logic        l, s;
        int          dly, exp_req;
        logic        exp_to;
        for (int i = 0; i < 40; i++) begin
            s = 1'($urandom_range(0, 1));
            l = 1'($urandom_range(0, 1));
            if (!s) l = 1'b1;
            sz = s ? sizes[$urandom_range(0, 2)] : sizes[$urandom_range(0, 4)];
            a = $urandom; d = $urandom; w = $urandom;
            if (sz[1:0] == 2'b01) a[0] = 1'b0;
            if (sz[1:0] == 2'b10) a[1:0] = 2'b00;
            dly = $urandom_range(0, 4);
            exp_to = (dly >= 4);
            exp_req = exp_to ? 4 : dly + 1;
            run_op(l, s, sz, a, d, dly, w);
            if ({o_done, o_req_cyc[3:0], o_stall_cyc[3:0], o_berr}
                !== {1'b1, 4'(exp_req), 4'(exp_req + 1), exp_to}) begin
                $display("FAIL rnd_timing i=%0d done=%0d req=%0d stall=%0d berr=%b exp req=%0d to=%b",
                         i, o_done, o_req_cyc, o_stall_cyc, o_berr, exp_req, exp_to);
            end else n_pass++;
            n_chk++;
            if ({o_be, o_addr, o_we, o_unstable[3:0]}
                !== {m_be(sz, a), a & 32'hFFFFFFFC, s, 4'd0}) begin
                $display("FAIL rnd_bus i=%0d be=%b addr=%h we=%b unst=%0d exp be=%b",
                         i, o_be, o_addr, o_we, o_unstable, m_be(sz, a));
            end else n_pass++;
            n_chk++;
            if (s) begin
                if (o_wdata !== m_wdata(sz, d)) begin
                    $display("FAIL rnd_wdata i=%0d got=%h exp=%h", i, o_wdata, m_wdata(sz, d));
                end else n_pass++;
                n_chk++;
            end else begin
                if (o_rdata !== (exp_to ? 32'h0 : m_load(sz, a, w))) begin
                    $display("FAIL rnd_rdata i=%0d got=%h exp=%h", i, o_rdata,
                             exp_to ? 32'h0 : m_load(sz, a, w));
                end else n_pass++;
                n_chk++;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_lw();
        test_lb_lbu();
        test_sh();
        test_misalign();
        test_timeout();
        test_rst_mid_req();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
